// File: rtl/key_expand_seq.sv
// Sequential key expansion for the 16-bit simplified-AES datapath.
// A start pulse loads the cipher key into bank[0]. Each following cycle, one
// RotNib/SubNib/Rcon round produces the next round key, until NROUNDS keys
// have been written. The round datapath reads the key bank by index through
// a purely combinational mux.

module key_expand_seq #(
  parameter int unsigned NROUNDS = 2,
  parameter int unsigned IDXW    = $clog2(NROUNDS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     key,
  output logic            busy,
  output logic            done,
  output logic            keys_valid,
  input  logic [IDXW-1:0] rd_idx,
  output logic [15:0]     rd_key
);

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  localparam logic [IDXW-1:0] LastIdx = IDXW'(NROUNDS);
  localparam logic [3:0]      RconInit = 4'b1000;

  state_e          state_q;
  logic            busy_q;
  logic            done_q;
  logic            keys_valid_q;
  logic [IDXW-1:0] cnt_q;
  logic [3:0]      rcon_q;
  logic [7:0]      wa_q;
  logic [7:0]      wb_q;
  logic [15:0]     bank_q [NROUNDS+1];

  logic [7:0]      sub_w;
  logic [7:0]      na;
  logic [7:0]      nb;
  logic [3:0]      rcon_next;

  // Simplified-AES 4-bit S-box.
  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] s;
    case (n)
      4'h0: s = 4'h9;
      4'h1: s = 4'h4;
      4'h2: s = 4'hA;
      4'h3: s = 4'hB;
      4'h4: s = 4'hD;
      4'h5: s = 4'h1;
      4'h6: s = 4'h8;
      4'h7: s = 4'h5;
      4'h8: s = 4'h6;
      4'h9: s = 4'h2;
      4'hA: s = 4'h0;
      4'hB: s = 4'h3;
      4'hC: s = 4'hC;
      4'hD: s = 4'hE;
      4'hE: s = 4'hF;
      default: s = 4'h7;
    endcase
    return s;
  endfunction

  // One shared round: RotNib+SubNib on wb, fold in Rcon, chain into wb.
  always_comb begin
    sub_w     = {sbox(wb_q[3:0]), sbox(wb_q[7:4])};
    na        = wa_q ^ sub_w ^ {rcon_q, 4'b0000};
    nb        = wb_q ^ na;
    // xtime in GF(2^4) modulo x^4 + x + 1
    rcon_next = {rcon_q[2:0], 1'b0} ^ (rcon_q[3] ? 4'b0011 : 4'b0000);
  end

  // Control FSM, working words and key bank; reset also wipes the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      cnt_q        <= '0;
      rcon_q       <= RconInit;
      wa_q         <= '0;
      wb_q         <= '0;
      bank_q       <= '{default: '0};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            bank_q[0]    <= key;
            wa_q         <= key[15:8];
            wb_q         <= key[7:0];
            cnt_q        <= IDXW'(1);
            rcon_q       <= RconInit;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StExpand;
          end
        end
        StExpand: begin
          bank_q[cnt_q] <= {na, nb};
          wa_q          <= na;
          wb_q          <= nb;
          cnt_q         <= cnt_q + 1'b1;
          rcon_q        <= rcon_next;
          if (cnt_q == LastIdx) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Zero-latency bank read; out-of-range indices read as zero.
  always_comb begin
    rd_key = '0;
    if (32'(rd_idx) <= NROUNDS) begin
      rd_key = bank_q[rd_idx];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: two instances (NROUNDS=2 and NROUNDS=3) checked
// against known-answer vectors and a behavioural key-schedule model.

module tb_key_expand_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        s2 = 1'b0, s3 = 1'b0;
  logic [15:0] k2 = '0, k3 = '0;
  logic [1:0]  i2 = '0, i3 = '0;
  logic        b2, d2, v2, b3, d3, v3;
  logic [15:0] r2, r3;

  int checks = 0;
  int errors = 0;

  logic [3:0]  sbox_tbl [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                 4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  logic [15:0] exp_keys [16];

  key_expand_seq #(.NROUNDS(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (s2),
    .key        (k2),
    .busy       (b2),
    .done       (d2),
    .keys_valid (v2),
    .rd_idx     (i2),
    .rd_key     (r2)
  );

  key_expand_seq #(.NROUNDS(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (s3),
    .key        (k3),
    .busy       (b3),
    .done       (d3),
    .keys_valid (v3),
    .rd_idx     (i3),
    .rd_key     (r3)
  );

  always #5 clk = ~clk;

  // Reference schedule: plain arithmetic over bytes, Rcon as powers of x mod x^4+x+1.
  task automatic model_expand(input logic [15:0] k, input int n);
    logic [7:0] a, b, t;
    int rc;
    a = k[15:8];
    b = k[7:0];
    rc = 8;
    exp_keys[0] = k;
    for (int i = 1; i <= n; i++) begin
      t = {sbox_tbl[b[3:0]], sbox_tbl[b[7:4]]};
      a = a ^ t ^ 8'(rc * 16);
      b = b ^ a;
      exp_keys[i] = {a, b};
      rc = rc * 2;
      if (rc > 15) rc = rc ^ 19;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int sel, input logic v, input logic [15:0] k);
    if (sel == 2) begin
      s2 = v; k2 = k;
    end else begin
      s3 = v; k3 = k;
    end
  endtask

  task automatic read_bank(input int sel, input int idx, output logic [15:0] val);
    if (sel == 2) begin
      i2 = 2'(idx); #1 val = r2;
    end else begin
      i3 = 2'(idx); #1 val = r3;
    end
  endtask

  task automatic get_status(input int sel, output logic b, output logic d, output logic v);
    if (sel == 2) begin
      b = b2; d = d2; v = v2;
    end else begin
      b = b3; d = d3; v = v3;
    end
  endtask

  // Pulse start for one accepting edge; returns just after that edge.
  task automatic pulse_start(input int sel, input logic [15:0] k);
    drive_start(sel, 1'b1, k);
    tick();
    drive_start(sel, 1'b0, k);
  endtask

  // Advance until done is seen (bounded); cyc = edges waited, -1 on timeout.
  task automatic wait_done(input int sel, output int cyc);
    logic b, d, v;
    cyc = -1;
    for (int c = 0; c < 20; c++) begin
      get_status(sel, b, d, v);
      if (d) begin
        cyc = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [15:0] val;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({b2, d2, v2} !== 3'b000) begin
      errors++; $display("FAIL reset_flags2: got %b want 000", {b2, d2, v2});
    end
    checks++;
    if ({b3, d3, v3} !== 3'b000) begin
      errors++; $display("FAIL reset_flags3: got %b want 000", {b3, d3, v3});
    end
    for (int i = 0; i < 4; i++) begin
      read_bank(2, i, val);
      checks++;
      if (val !== 16'h0000) begin
        errors++; $display("FAIL reset_bank2[%0d]: got %h want 0000", i, val);
      end
      read_bank(3, i, val);
      checks++;
      if (val !== 16'h0000) begin
        errors++; $display("FAIL reset_bank3[%0d]: got %h want 0000", i, val);
      end
    end
  endtask

  task automatic test_standard();
    logic [15:0] val;
    logic [15:0] want [3];
    int dc;
    int extra;
    want = '{16'h4AF5, 16'hDD28, 16'h87AF};
    pulse_start(2, 16'h4AF5);
    read_bank(2, 0, val);
    checks++;
    if (val !== 16'h4AF5) begin
      errors++; $display("FAIL std_bank0_early: got %h want 4af5", val);
    end
    checks++;
    if ({b2, d2, v2} !== 3'b100) begin
      errors++; $display("FAIL std_busy_after_accept: got %b want 100", {b2, d2, v2});
    end
    wait_done(2, dc);
    checks++;
    if (dc !== 2) begin
      errors++; $display("FAIL std_done_latency: got %0d want 2", dc);
    end
    checks++;
    if ({b2, v2} !== 2'b01) begin
      errors++; $display("FAIL std_flags_at_done: got %b want 01", {b2, v2});
    end
    for (int i = 0; i < 3; i++) begin
      read_bank(2, i, val);
      checks++;
      if (val !== want[i]) begin
        errors++; $display("FAIL std_key[%0d]: got %h want %h", i, val, want[i]);
      end
    end
    read_bank(2, 3, val);
    checks++;
    if (val !== 16'h0000) begin
      errors++; $display("FAIL std_out_of_range: got %h want 0000", val);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d2) extra++;
    end
    checks++;
    if (extra !== 0 || v2 !== 1'b1) begin
      errors++; $display("FAIL std_single_done: extra %0d kv %b want 0 1", extra, v2);
    end
  endtask

  task automatic test_nrounds3();
    logic [15:0] val;
    logic [15:0] want [4];
    int dc;
    want = '{16'h4AF5, 16'hDD28, 16'h87AF, 16'h9738};
    pulse_start(3, 16'h4AF5);
    wait_done(3, dc);
    checks++;
    if (dc !== 3) begin
      errors++; $display("FAIL nr3_done_latency: got %0d want 3", dc);
    end
    for (int i = 0; i < 4; i++) begin
      read_bank(3, i, val);
      checks++;
      if (val !== want[i]) begin
        errors++; $display("FAIL nr3_key[%0d]: got %h want %h", i, val, want[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] val;
    int dc;
    pulse_start(2, 16'h0000);
    wait_done(2, dc);
    checks++;
    if (dc !== 2) begin
      errors++; $display("FAIL b2b_first_latency: got %0d want 2", dc);
    end
    read_bank(2, 1, val);
    checks++;
    if (val !== 16'h1919) begin
      errors++; $display("FAIL b2b_zero_key1: got %h want 1919", val);
    end
    read_bank(2, 2, val);
    checks++;
    if (val !== 16'h0D14) begin
      errors++; $display("FAIL b2b_zero_key2: got %h want 0d14", val);
    end
    // Start asserted in the done cycle must be accepted.
    pulse_start(2, 16'h4AF5);
    checks++;
    if ({b2, v2} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept: busy,kv got %b want 10", {b2, v2});
    end
    wait_done(2, dc);
    checks++;
    if (dc !== 2) begin
      errors++; $display("FAIL b2b_second_latency: got %0d want 2", dc);
    end
    read_bank(2, 1, val);
    checks++;
    if (val !== 16'hDD28) begin
      errors++; $display("FAIL b2b_key1: got %h want dd28", val);
    end
    read_bank(2, 2, val);
    checks++;
    if (val !== 16'h87AF) begin
      errors++; $display("FAIL b2b_key2: got %h want 87af", val);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    logic [15:0] val;
    int dc;
    int extra;
    pulse_start(2, 16'h4AF5);
    pulse_start(2, 16'hFFFF);
    wait_done(2, dc);
    checks++;
    if (dc !== 1) begin
      errors++; $display("FAIL busy_start_latency: got %0d want 1", dc);
    end
    read_bank(2, 0, val);
    checks++;
    if (val !== 16'h4AF5) begin
      errors++; $display("FAIL busy_start_key0: got %h want 4af5", val);
    end
    read_bank(2, 1, val);
    checks++;
    if (val !== 16'hDD28) begin
      errors++; $display("FAIL busy_start_key1: got %h want dd28", val);
    end
    read_bank(2, 2, val);
    checks++;
    if (val !== 16'h87AF) begin
      errors++; $display("FAIL busy_start_key2: got %h want 87af", val);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d2) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL busy_start_done_count: extra %0d want 0", extra);
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] val;
    int dc;
    int seen;
    pulse_start(2, 16'h4AF5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({b2, d2, v2} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 000", {b2, d2, v2});
    end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (d2 || b2 || v2) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_mid_quiet: activity cycles %0d want 0", seen);
    end
    for (int i = 0; i < 4; i++) begin
      read_bank(2, i, val);
      checks++;
      if (val !== 16'h0000) begin
        errors++; $display("FAIL rst_mid_bank[%0d]: got %h want 0000", i, val);
      end
    end
    pulse_start(2, 16'h4AF5);
    wait_done(2, dc);
    read_bank(2, 2, val);
    checks++;
    if (dc !== 2 || val !== 16'h87AF) begin
      errors++; $display("FAIL rst_mid_restart: latency %0d key2 %h want 2 87af", dc, val);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] k, val;
    int dc;
    for (int it = 0; it < 6; it++) begin
      for (int sel = 2; sel <= 3; sel++) begin
        k = 16'($urandom);
        model_expand(k, sel);
        pulse_start(sel, k);
        wait_done(sel, dc);
        checks++;
        if (dc !== sel) begin
          errors++; $display("FAIL rand_latency n=%0d: got %0d want %0d", sel, dc, sel);
        end
        for (int i = 0; i <= sel; i++) begin
          read_bank(sel, i, val);
          checks++;
          if (val !== exp_keys[i]) begin
            errors++;
            $display("FAIL rand_key n=%0d key=%h [%0d]: got %h want %h",
                     sel, k, i, val, exp_keys[i]);
          end
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_nrounds3();
    test_back_to_back();
    test_start_while_busy();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
